if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- RV32I instruction-fetch stage, directly upstream of the decode/control stage.
- Holds the PC and issues in-order requests to instruction memory over a valid/ready request channel.
- Buffers returned words in a small FIFO and presents {inst, inst_pc} to decode with a valid/ready handshake.
- Handles redirects from jumps/branches by flushing the FIFO and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2); also the cap on outstanding requests.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address (word aligned).
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_resp_valid  in  1  response word valid; one per accepted request, in order, ≥1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- redirect  in  1  PC redirect (jal/jalr/taken branch).
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- inst_valid  out  1  inst/inst_pc valid toward decode.
- inst  out  32  instruction to decode; NOP 32'h0000_0013 when inst_valid=0.
- inst_pc  out  32  PC of inst.
- inst_ready  in  1  decode consumes the head entry when inst_valid & inst_ready.

Behaviour:
- Reset (async, reset=0): pc=RESET_PC, state=IDLE, FIFO empty, outstanding=0, drop_cnt=0, imem_req_valid=0, inst_valid=0, inst=NOP, inst_pc=RESET_PC.
- States:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: normal operation.
  - FLUSH: discarding stale responses.
- Request issue (FETCH only):
  - imem_req_valid=1 iff outstanding + fifo_count < FIFO_DEPTH and redirect=0.
  - imem_req_addr=pc.
  - On req accept (valid & ready): pc+=4, wrapping modulo 2^32; outstanding+=1.
  - A request tag FIFO holds the PC of each in-flight request.
- Response:
  - In FETCH, imem_resp_valid pushes {data, tag pc} into the FIFO and decrements outstanding.
  - The credit rule guarantees no overflow. A response arriving with outstanding=0 is a protocol error; the bench flags it.
- Output: head of the FIFO. Latency from response to inst_valid is 1 cycle; 0 cycles with IF_BYPASS_EN when the FIFO is empty.
- Simultaneous push and pop with a full FIFO is legal; count is unchanged.
- Redirect (any state, highest priority):
  - pc←{redirect_pc[31:2],2'b00}.
  - FIFO cleared; inst_valid=0 in the following cycle.
  - drop_cnt←outstanding minus any response arriving in the same cycle; that response is discarded.
  - The tag FIFO is cleared and outstanding←drop_cnt.
  - Next state: FLUSH if the new drop_cnt≠0, else FETCH.
  - imem_req_valid=0 in the redirect cycle.
- FLUSH:
  - No requests issued.
  - Each imem_resp_valid decrements drop_cnt and outstanding; the data is discarded.
  - At drop_cnt reaching 0, go to FETCH.
  - A new redirect in FLUSH updates pc only; drop_cnt is unchanged.
- Back-pressure: inst_ready=0 holds inst/inst_pc stable while inst_valid=1.
- Reset mid-operation: everything returns to reset values immediately. The memory is reset in the same domain, so no responses are dropped.

Optional Feature:
- IF_BYPASS_EN defined:
  - When the FIFO is empty and a FETCH-state response arrives, it drives inst/inst_pc/inst_valid combinationally in the same cycle.
  - If inst_ready=1 in that cycle, it is not written into the FIFO.
- Undefined: responses always enter the FIFO first, giving 1-cycle latency. This is the default build.

Decomposition:
- Package rv32_pkg: RESET_PC default, NOP_INST=32'h0000_0013, state enum typedef {IDLE, FETCH, FLUSH}, RV32I opcode localparams shared with decode.
- Sub-module if_inst_fifo:
  - Parameterised DEPTH×WIDTH synchronous FIFO with async active-low reset and a flush input.
  - Instantiated twice: instruction FIFO, 64-bit {pc, inst}; tag FIFO, 32-bit.

Test Plan:
- Reset release, memory always ready, 1-cycle response latency, inst_ready=1 → requests at 0x0, 0x4, 0x8…; first inst_valid at cycle 3 after release; inst_pc sequence 0x0, 0x4, 0x8.
- inst_ready=0 for 5 cycles with FIFO_DEPTH=2 → exactly 2 requests accepted; imem_req_valid then stays 0; inst holds the word at 0x0; resumes in order after ready returns.
- Redirect to 0x103 with 2 requests outstanding → next request address 0x100; two stale responses dropped; first inst_pc=0x100; no 0x8/0xC words reach decode.
- Redirect coincident with a response and a second redirect to 0x200 while in FLUSH → all stale data dropped; fetch resumes at 0x200.
- PC at 0xFFFF_FFFC → next request address 0x0000_0000.
- IF_BYPASS_EN build, empty FIFO, response with inst_ready=1 → inst_valid and data in the same cycle; FIFO count stays 0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the fetch and decode stages: reset PC, NOP encoding,
// fetch FSM states, buffer entry layout and base opcodes.
package rv32_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_inst_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with flush; DEPTH must be a power of two (>= 2).
// Push while full is accepted only when a pop happens in the same cycle.
module if_inst_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FullCnt) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: nothing is read past the count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I fetch stage: PC, credit-limited imem requests, instruction buffer and redirect flush.
// Build option IF_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module if_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CreditMax = (CW+1)'(FIFO_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [CW-1:0] fifo_count, tag_count;
  logic          fifo_empty, tag_empty, unused_tag;
  logic [31:0]   tag_pc;
  fetch_entry_t  fifo_head, resp_entry, out_entry;
  logic          req_fire, resp_fetch, resp_flush, bypass, fifo_push, fifo_pop;

  // Outstanding requests plus buffered words never exceed the buffer depth.
  assign imem_req_valid = (state_q == FETCH) && !redirect &&
                          (({1'b0, outst_q} + {1'b0, fifo_count}) < CreditMax);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_fetch = imem_resp_valid && (state_q == FETCH) && !redirect;
  assign resp_flush = imem_resp_valid && (state_q == FLUSH);
  assign resp_entry = '{pc: tag_pc, inst: imem_resp_data};

`ifdef IF_BYPASS_EN
  assign bypass = fifo_empty && resp_fetch;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push  = resp_fetch && !(bypass && inst_ready);
  assign fifo_pop   = inst_ready && !fifo_empty;
  assign unused_tag = ^{tag_empty, tag_count};

  if_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_inst_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (redirect),
    .push  (fifo_push),
    .wdata (resp_entry),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Holds the PC of every in-flight request, in issue order.
  if_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (redirect),
    .push  (req_fire),
    .wdata (pc_q),
    .pop   (resp_fetch),
    .rdata (tag_pc),
    .empty (tag_empty),
    .count (tag_count)
  );

  always_comb begin
    inst_valid = !fifo_empty;
    out_entry  = fifo_head;
    if (bypass) begin
      inst_valid = 1'b1;
      out_entry  = resp_entry;
    end
    inst    = inst_valid ? out_entry.inst : NOP_INST;
    inst_pc = inst_valid ? out_entry.pc : pc_q;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    if (state_q == FLUSH) begin
      // A redirect while draining only retargets the PC; the drop count stands.
      if (redirect) pc_d = align_word(redirect_pc);
      if (resp_flush) begin
        drop_d  = drop_q - CW'(1);
        outst_d = outst_q - CW'(1);
      end
      if (drop_d == '0) state_d = FETCH;
    end else if (redirect) begin
      pc_d    = align_word(redirect_pc);
      drop_d  = outst_q - CW'(imem_resp_valid);
      outst_d = drop_d;
      state_d = (drop_d != '0) ? FLUSH : FETCH;
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (req_fire) pc_d = pc_q + 32'd4;
          outst_d = outst_q + CW'(req_fire) - CW'(resp_fetch);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: in-order memory model, expected-PC scoreboard,
// redirect vector table and hand-written flush/back-pressure/reset sequences.
module tb_if_fetch_unit;
  import rv32_pkg::*;

  localparam int unsigned Depth   = 2;
  localparam logic [31:0] ResetPc = 32'h0000_0000;
`ifdef IF_BYPASS_EN
  localparam int FirstValidCyc = 2;
`else
  localparam int FirstValidCyc = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;

  if_fetch_unit #(
    .RESET_PC   (ResetPc),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] tgt;
    int          lat;
    logic [31:0] first;
    logic [31:0] second;
  } vec_t;

  mreq_t       pending[$];
  logic [31:0] exp_q[$];
  vec_t        vecs[4];
  int          n_cmp, n_bad, cyc, pops, req_cnt, first_valid, mem_lat, stale;
  logic [31:0] exp_req_addr, hold_inst, hold_pc;
  bit          hold;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_expect(input logic [31:0] first, input logic [31:0] second);
    exp_q.delete();
    exp_q.push_back(first);
    for (int i = 0; i < 40; i++) exp_q.push_back(second + 32'(4 * i));
    pops = 0;
  endtask

  task automatic reset_model();
    pending.delete();
    stale           = 0;
    hold            = 1'b0;
    req_cnt         = 0;
    first_valid     = -1;
    exp_req_addr    = ResetPc;
    cyc             = 0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    load_expect(ResetPc, ResetPc + 32'd4);
  endtask

  // One clock cycle: observe at the falling edge, then drive memory just after the rising edge.
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    if (hold) begin
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_inst", inst, hold_inst);
      check("hold_pc", inst_pc, hold_pc);
    end
    hold      = inst_valid && !inst_ready && !redirect;
    hold_inst = inst;
    hold_pc   = inst_pc;
    if (!inst_valid) check("nop_when_invalid", inst, NOP_INST);
    if (inst_valid && first_valid < 0) first_valid = cyc;
    if (redirect) check("req_in_redirect", 32'(imem_req_valid), 32'd0);
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_req_addr);
      check("req_in_flush", 32'(stale), 32'd0);
      pending.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      exp_req_addr = exp_req_addr + 32'd4;
      req_cnt++;
    end
    if (inst_valid && inst_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_inst: got pc %h, expected no instruction", inst_pc);
      end else begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e);
        check("inst_word", inst, mem_word(e));
        pops++;
      end
    end
    if (redirect) begin
      if (stale == 0) stale = pending.size();
      else if (imem_resp_valid) stale--;
    end else if (imem_resp_valid && stale > 0) begin
      stale--;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  endtask

  task automatic do_redirect(input logic [31:0] tgt, input logic [31:0] first,
                             input logic [31:0] second);
    redirect     = 1'b1;
    redirect_pc  = tgt;
    exp_req_addr = first;
    load_expect(first, second);
    step();
    redirect = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    int k = 0;
    while (pops < n && k < budget) begin
      step();
      k++;
    end
    check(name, 32'(pops), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_inst"}, inst, NOP_INST);
    check({tag, "_inst_pc"}, inst_pc, ResetPc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    n_cmp          = 0;
    n_bad          = 0;
    mem_lat        = 1;
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    vecs[0] = '{tgt: 32'h0000_0103, lat: 1, first: 32'h0000_0100, second: 32'h0000_0104};
    vecs[1] = '{tgt: 32'hFFFF_FFFC, lat: 1, first: 32'hFFFF_FFFC, second: 32'h0000_0000};
    vecs[2] = '{tgt: 32'h0000_07FF, lat: 2, first: 32'h0000_07FC, second: 32'h0000_0800};
    vecs[3] = '{tgt: 32'h1234_5672, lat: 3, first: 32'h1234_5670, second: 32'h1234_5674};
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Release with decode stalled: credit limit caps issue at Depth requests.
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
    repeat (8) step();
    check("first_valid_cyc", 32'(first_valid), 32'(FirstValidCyc));
    check("credit_req_cnt", 32'(req_cnt), Depth);
    check("credit_req_valid", 32'(imem_req_valid), 32'd0);
    check("held_pc", inst_pc, ResetPc);
    check("held_inst", inst, mem_word(ResetPc));
    inst_ready = 1'b1;
    wait_pops(5, 40, "resume_in_order");

    foreach (vecs[i]) begin
      mem_lat = vecs[i].lat;
      repeat (3) step();
      do_redirect(vecs[i].tgt, vecs[i].first, vecs[i].second);
      wait_pops(2, 40, "vec_first_two");
    end

    // Redirect with two requests in flight and no response in that cycle.
    mem_lat = 4;
    k = 0;
    while (!(pending.size() == 2 && !imem_resp_valid) && k < 30) begin
      step();
      k++;
    end
    check("two_outstanding_setup", 32'(pending.size()), 32'd2);
    do_redirect(32'h0000_0103, 32'h0000_0100, 32'h0000_0104);
    wait_pops(3, 60, "redirect_drop_two");

    // Redirect coincident with a response, then a second redirect while draining.
    mem_lat = 3;
    k = 0;
    while (!(imem_resp_valid && pending.size() >= 1) && k < 30) begin
      step();
      k++;
    end
    check("coincident_setup", 32'(imem_resp_valid), 32'd1);
    do_redirect(32'h0000_0300, 32'h0000_0300, 32'h0000_0304);
    do_redirect(32'h0000_0200, 32'h0000_0200, 32'h0000_0204);
    wait_pops(3, 60, "flush_redirect_0x200");

    // Asynchronous reset in the middle of traffic.
    mem_lat = 1;
    repeat (4) step();
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    reset_model();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
    wait_pops(3, 40, "restart_after_reset");
    check("restart_first_valid", 32'(first_valid), 32'(FirstValidCyc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
